// File: rtl/s_axi_regfile_pkg.sv
// Shared types and constants for the s_axi_regfile AXI4 register bank.
// Response codes, supported burst encodings and the two channel FSM state types.
package s_axi_regfile_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01
   } burst_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   // WRAP and the reserved encoding are rejected for the whole transaction.
   function automatic logic burst_ok(input logic [1:0] burst);
      return (burst == 2'(BURST_FIXED)) || (burst == 2'(BURST_INCR));
   endfunction

endpackage

// File: rtl/s_axi_regfile_addr_gen.sv
// Burst beat counter and register index generator for one AXI channel.
// Reports the current beat and a one-beat lookahead (used by the registered read path).
module s_axi_regfile_addr_gen
   import s_axi_regfile_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             load,
   input  logic [IDX_W-1:0] start_idx,
   input  logic [7:0]       len,
   input  logic [1:0]       burst,
   input  logic             step,
   output logic [IDX_W-1:0] idx,
   output logic [7:0]       beat,
   output logic             last,
   output logic             oor,
   output logic [IDX_W-1:0] nxt_idx,
   output logic             nxt_last,
   output logic             nxt_oor
);

   // Wide enough for start (<256) plus beat count (<=256) without overflow.
   localparam int UW = 10;

   logic [IDX_W-1:0] start_reg;
   logic [7:0]       len_reg;
   logic [7:0]       beat_reg;
   logic             incr_reg;
   logic [UW-1:0]    cur_u;
   logic [UW-1:0]    nxt_u;

   always_ff @(posedge clk) begin
      if (areset) begin
         start_reg <= '0;
         len_reg   <= '0;
         beat_reg  <= '0;
         incr_reg  <= 1'b0;
      end else if (load) begin
         start_reg <= start_idx;
         len_reg   <= len;
         beat_reg  <= '0;
         incr_reg  <= (burst == 2'(BURST_INCR));
      end else if (step) begin
         beat_reg  <= beat_reg + 8'd1;
      end
   end

   // Unwrapped index: the low bits address the bank, the full value flags overrun.
   always_comb begin
      cur_u = UW'(start_reg) + (incr_reg ? UW'(beat_reg) : UW'(0));
      nxt_u = cur_u + (incr_reg ? UW'(1) : UW'(0));
   end

   assign idx      = cur_u[IDX_W-1:0];
   assign beat     = beat_reg;
   assign last     = (beat_reg == len_reg);
   assign oor      = (cur_u >= UW'(DEPTH));
   assign nxt_idx  = nxt_u[IDX_W-1:0];
   assign nxt_last = (({1'b0, beat_reg} + 9'd1) == {1'b0, len_reg});
   assign nxt_oor  = (nxt_u >= UW'(DEPTH));

endmodule

// File: rtl/s_axi_regfile.sv
// Parametrised AXI4 slave register bank with FIXED/INCR bursts, strobes and ID echo.
// Optional range/WLAST checking is enabled by defining S_AXI_REGFILE_RESP_ERR_EN.
module s_axi_regfile
   import s_axi_regfile_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                DEPTH     = 16,
   parameter int                ID_W      = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                clk,
   input  logic                areset,
   input  logic [ID_W-1:0]     awid_i,
   input  logic [ADDR_W-1:0]   awaddr_i,
   input  logic [7:0]          awlen_i,
   input  logic [1:0]          awburst_i,
   input  logic                awvalid_i,
   output logic                awready_o,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   input  logic                wlast_i,
   input  logic                wvalid_i,
   output logic                wready_o,
   output logic [ID_W-1:0]     bid_o,
   output logic [1:0]          bresp_o,
   output logic                bvalid_o,
   input  logic                bready_i,
   input  logic [ID_W-1:0]     arid_i,
   input  logic [ADDR_W-1:0]   araddr_i,
   input  logic [7:0]          arlen_i,
   input  logic [1:0]          arburst_i,
   input  logic                arvalid_i,
   output logic                arready_o,
   output logic [ID_W-1:0]     rid_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic [1:0]          rresp_o,
   output logic                rlast_o,
   output logic                rvalid_o,
   input  logic                rready_i
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_reg [DEPTH];
   wr_state_t w_state_reg, w_state_next;
   rd_state_t r_state_reg, r_state_next;

   logic [ID_W-1:0]   bid_reg, rid_reg;
   logic [1:0]        bresp_reg, rresp_reg, w_resp_final;
   logic [DATA_W-1:0] rdata_reg, wbyte_mask;
   logic              rlast_reg, w_berr_reg, r_berr_reg;
   logic              aw_hs, w_hs, ar_hs, rd_hs, w_we;
   logic [IDX_W-1:0]  ar_idx;

   logic [IDX_W-1:0]  w_idx, w_nxt_idx, r_idx, r_nxt_idx;
   logic [7:0]        w_beat, r_beat;
   logic              w_last, w_oor, w_nxt_last, w_nxt_oor;
   logic              r_last, r_oor, r_nxt_last, r_nxt_oor;
   logic              unused_sigs;

   assign aw_hs  = awvalid_i & awready_o;
   assign w_hs   = wvalid_i & wready_o;
   assign ar_hs  = arvalid_i & arready_o;
   assign rd_hs  = rvalid_o & rready_i;
   assign ar_idx = araddr_i[OFF_W +: IDX_W];

   s_axi_regfile_addr_gen #(.DEPTH(DEPTH)) u_wr_gen (
      .clk(clk), .areset(areset), .load(aw_hs), .start_idx(awaddr_i[OFF_W +: IDX_W]),
      .len(awlen_i), .burst(awburst_i), .step(w_hs & ~w_last),
      .idx(w_idx), .beat(w_beat), .last(w_last), .oor(w_oor),
      .nxt_idx(w_nxt_idx), .nxt_last(w_nxt_last), .nxt_oor(w_nxt_oor)
   );

   s_axi_regfile_addr_gen #(.DEPTH(DEPTH)) u_rd_gen (
      .clk(clk), .areset(areset), .load(ar_hs), .start_idx(ar_idx),
      .len(arlen_i), .burst(arburst_i), .step(rd_hs & ~rlast_reg),
      .idx(r_idx), .beat(r_beat), .last(r_last), .oor(r_oor),
      .nxt_idx(r_nxt_idx), .nxt_last(r_nxt_last), .nxt_oor(r_nxt_oor)
   );

   always_ff @(posedge clk) begin
      if (areset) begin
         w_state_reg <= W_IDLE;
         r_state_reg <= R_IDLE;
      end else begin
         w_state_reg <= w_state_next;
         r_state_reg <= r_state_next;
      end
   end

   always_comb begin
      w_state_next = w_state_reg;
      awready_o    = 1'b0;
      wready_o     = 1'b0;
      bvalid_o     = 1'b0;
      case (w_state_reg)
         W_IDLE: begin
            awready_o = 1'b1;
            if (awvalid_i) w_state_next = W_DATA;
         end
         W_DATA: begin
            wready_o = 1'b1;
            if (wvalid_i && w_last) w_state_next = W_RESP;
         end
         W_RESP: begin
            bvalid_o = 1'b1;
            if (bready_i) w_state_next = W_IDLE;
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_next = r_state_reg;
      arready_o    = 1'b0;
      rvalid_o     = 1'b0;
      case (r_state_reg)
         R_IDLE: begin
            arready_o = 1'b1;
            if (arvalid_i) r_state_next = R_DATA;
         end
         R_DATA: begin
            rvalid_o = 1'b1;
            if (rready_i && rlast_reg) r_state_next = R_IDLE;
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   for (genvar gi = 0; gi < STRB_W; gi++) begin : g_mask
      assign wbyte_mask[gi*8 +: 8] = {8{wstrb_i[gi]}};
   end

`ifdef S_AXI_REGFILE_RESP_ERR_EN
   logic w_decerr_reg, w_lasterr_reg;

   assign w_we = w_hs & ~w_berr_reg & ~w_oor;

   // Sticky flags include the beat being accepted now, so the final beat counts.
   always_comb begin
      w_resp_final = RESP_OKAY;
      if (w_decerr_reg || w_oor)
         w_resp_final = RESP_DECERR;
      else if (w_berr_reg || w_lasterr_reg || (wlast_i != w_last))
         w_resp_final = RESP_SLVERR;
   end

   always_ff @(posedge clk) begin
      if (areset || aw_hs) begin
         w_decerr_reg  <= 1'b0;
         w_lasterr_reg <= 1'b0;
      end else if (w_hs) begin
         w_decerr_reg  <= w_decerr_reg | w_oor;
         w_lasterr_reg <= w_lasterr_reg | (wlast_i != w_last);
      end
   end
`else
   assign w_we = w_hs & ~w_berr_reg;

   always_comb begin
      w_resp_final = w_berr_reg ? RESP_SLVERR : RESP_OKAY;
   end
`endif

   always_ff @(posedge clk) begin
      if (areset) begin
         bid_reg    <= '0;
         bresp_reg  <= RESP_OKAY;
         w_berr_reg <= 1'b0;
      end else begin
         if (aw_hs) begin
            bid_reg    <= awid_i;
            w_berr_reg <= ~burst_ok(awburst_i);
         end
         if (w_hs && w_last) bresp_reg <= w_resp_final;
      end
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= RESET_VAL;
      end else if (w_we) begin
         mem_reg[w_idx] <= (mem_reg[w_idx] & ~wbyte_mask) | (wdata_i & wbyte_mask);
      end
   end

   // Read data is fetched one beat ahead so the next beat is ready right after a handshake.
   always_ff @(posedge clk) begin
      if (areset) begin
         rid_reg    <= '0;
         rdata_reg  <= '0;
         rresp_reg  <= RESP_OKAY;
         rlast_reg  <= 1'b0;
         r_berr_reg <= 1'b0;
      end else if (ar_hs) begin
         rid_reg    <= arid_i;
         r_berr_reg <= ~burst_ok(arburst_i);
         rlast_reg  <= (arlen_i == 8'd0);
         rdata_reg  <= burst_ok(arburst_i) ? mem_reg[ar_idx] : '0;
         rresp_reg  <= burst_ok(arburst_i) ? RESP_OKAY : RESP_SLVERR;
      end else if (rd_hs) begin
         if (rlast_reg) begin
            rlast_reg <= 1'b0;
         end else begin
            rlast_reg <= r_nxt_last;
            if (r_berr_reg) begin
               rdata_reg <= '0;
               rresp_reg <= RESP_SLVERR;
`ifdef S_AXI_REGFILE_RESP_ERR_EN
            end else if (r_nxt_oor) begin
               rdata_reg <= '0;
               rresp_reg <= RESP_DECERR;
`endif
            end else begin
               rdata_reg <= mem_reg[r_nxt_idx];
               rresp_reg <= RESP_OKAY;
            end
         end
      end
   end

   assign bid_o   = bid_reg;
   assign bresp_o = bresp_reg;
   assign rid_o   = rid_reg;
   assign rdata_o = rdata_reg;
   assign rresp_o = rresp_reg;
   assign rlast_o = rlast_reg;

   assign unused_sigs = ^{awaddr_i, araddr_i, wlast_i, w_beat, w_nxt_idx, w_nxt_last,
                          w_nxt_oor, w_oor, r_idx, r_beat, r_last, r_oor, r_nxt_oor};

endmodule

// File: tb/tb_s_axi_regfile.sv
// Directed self-checking bench for s_axi_regfile (DEPTH=16, DATA_W=32).
// Expectations for the wrap-around burst follow S_AXI_REGFILE_RESP_ERR_EN when defined.
module tb_s_axi_regfile;

   localparam logic [31:0] RV = 32'h1357_9BDF;

   logic        clk = 1'b0;
   logic        areset;
   logic [3:0]  awid_i, arid_i, bid_o, rid_o;
   logic [31:0] awaddr_i, araddr_i, wdata_i, rdata_o;
   logic [7:0]  awlen_i, arlen_i;
   logic [1:0]  awburst_i, arburst_i, bresp_o, rresp_o;
   logic [3:0]  wstrb_i;
   logic        awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
   logic        arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] wd [16];
   logic [31:0] rd_q [16];
   logic [1:0]  rresp_q [16];
   logic        rlast_q [16];
   logic [1:0]  resp;
   logic [3:0]  id_got;

   s_axi_regfile #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(16), .ID_W(4), .RESET_VAL(RV)
   ) dut (
      .clk(clk), .areset(areset),
      .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awburst_i(awburst_i),
      .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
      .wvalid_i(wvalid_i), .wready_o(wready_o),
      .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arburst_i(arburst_i),
      .arvalid_i(arvalid_i), .arready_o(arready_o),
      .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
      .rvalid_o(rvalid_o), .rready_i(rready_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb,
                            output logic [1:0] r, output logic [3:0] bid);
      int n;
      awid_i = id; awaddr_i = addr; awlen_i = len; awburst_i = burst; awvalid_i = 1'b1;
      n = 0;
      while (!awready_o && n < 50) begin tick(); n++; end
      check("aw_ready", awready_o, 1);
      tick();
      awvalid_i = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wdata_i = wd[b]; wstrb_i = strb; wlast_i = (b == int'(len)); wvalid_i = 1'b1;
         n = 0;
         while (!wready_o && n < 50) begin tick(); n++; end
         check("w_ready", wready_o, 1);
         tick();
      end
      wvalid_i = 1'b0; wlast_i = 1'b0; bready_i = 1'b1;
      n = 0;
      while (!bvalid_o && n < 50) begin tick(); n++; end
      check("b_valid", bvalid_o, 1);
      r = bresp_o; bid = bid_o;
      tick();
      bready_i = 1'b0;
      $display("[TB] write id=%0h addr=%0h len=%0d burst=%0d strb=%0h -> bresp=%0d bid=%0h",
               id, addr, len, burst, strb, r, bid);
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle, output logic [3:0] rid);
      int n, beat, cyc;
      logic [32:0] held;
      arid_i = id; araddr_i = addr; arlen_i = len; arburst_i = burst; arvalid_i = 1'b1;
      n = 0;
      while (!arready_o && n < 50) begin tick(); n++; end
      check("ar_ready", arready_o, 1);
      tick();
      arvalid_i = 1'b0;
      check("r_latency", rvalid_o, 1);
      rid = rid_o;
      beat = 0; cyc = 0; n = 0;
      while (beat <= int'(len) && n < 600) begin
         rready_i = toggle ? (cyc % 2 == 0) : 1'b1;
         if (rvalid_o && rready_i) begin
            rd_q[beat] = rdata_o; rresp_q[beat] = rresp_o; rlast_q[beat] = rlast_o;
            beat++;
            tick();
         end else begin
            held = {rlast_o, rdata_o};
            tick();
            if (rvalid_o) check("r_stable", {rlast_o, rdata_o}, held);
         end
         cyc++; n++;
      end
      rready_i = 1'b0;
      check("r_beats", beat, int'(len) + 1);
      check("r_done", {rvalid_o, arready_o}, 2'b01);
      $display("[TB] read id=%0h addr=%0h len=%0d burst=%0d -> rid=%0h first=%0h", id, addr,
               len, burst, rid, rd_q[0]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      awid_i = '0; awaddr_i = '0; awlen_i = '0; awburst_i = '0; awvalid_i = 1'b0;
      wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
      arid_i = '0; araddr_i = '0; arlen_i = '0; arburst_i = '0; arvalid_i = 1'b0;
      rready_i = 1'b0;
      areset = 1'b1;
      repeat (3) tick();
      check("rst_hs", {awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o}, 6'b110000);
      check("rst_out", {bid_o, rid_o, bresp_o, rresp_o, rdata_o}, 64'h0);
      areset = 1'b0;
      tick();

      // Single write and readback
      wd[0] = 32'hDEAD_BEEF;
      axi_write(4'h3, 32'h4, 8'd0, 2'b01, 4'hF, resp, id_got);
      check("single_bresp", resp, 2'b00);
      check("single_bid", id_got, 4'h3);
      axi_read(4'h5, 32'h4, 8'd0, 2'b01, 1'b0, id_got);
      check("single_rdata", rd_q[0], 32'hDEAD_BEEF);
      check("single_rlast", rlast_q[0], 1'b1);
      check("single_rid", id_got, 4'h5);

      // Partial strobe merge on index 2
      wd[0] = 32'h1122_3344;
      axi_write(4'h1, 32'h8, 8'd0, 2'b01, 4'hF, resp, id_got);
      wd[0] = 32'hAABB_CCDD;
      axi_write(4'h1, 32'h8, 8'd0, 2'b01, 4'h5, resp, id_got);
      axi_read(4'h2, 32'h8, 8'd0, 2'b01, 1'b0, id_got);
      check("strb_rdata", rd_q[0], 32'h11BB_33DD);

      // INCR burst write 5..8, read back with rready toggling
      for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
      axi_write(4'h6, 32'd20, 8'd3, 2'b01, 4'hF, resp, id_got);
      check("incr_bresp", resp, 2'b00);
      axi_read(4'h7, 32'd20, 8'd3, 2'b01, 1'b1, id_got);
      for (int i = 0; i < 4; i++) begin
         check("incr_rdata", rd_q[i], 32'(i + 1));
         check("incr_rlast", rlast_q[i], (i == 3));
      end

      // FIXED burst: every beat lands on index 10, index 11 untouched
      wd[0] = 32'h0000_00A1; wd[1] = 32'h0000_00A2; wd[2] = 32'h0000_00A3;
      axi_write(4'h8, 32'd40, 8'd2, 2'b00, 4'hF, resp, id_got);
      axi_read(4'h8, 32'd40, 8'd1, 2'b00, 1'b0, id_got);
      check("fixed_b0", rd_q[0], 32'h0000_00A3);
      check("fixed_b1", rd_q[1], 32'h0000_00A3);
      axi_read(4'h8, 32'd44, 8'd0, 2'b01, 1'b0, id_got);
      check("fixed_next", rd_q[0], RV);

      // WRAP burst is rejected on both channels
      wd[0] = 32'hFFFF_FFFF; wd[1] = 32'hFFFF_FFFF;
      axi_write(4'h9, 32'd12, 8'd1, 2'b10, 4'hF, resp, id_got);
      check("wrap_bresp", resp, 2'b10);
      axi_read(4'h9, 32'd12, 8'd0, 2'b01, 1'b0, id_got);
      check("wrap_nowrite", rd_q[0], RV);
      axi_read(4'hA, 32'd16, 8'd1, 2'b10, 1'b0, id_got);
      check("wrap_rd", {rd_q[0], rresp_q[0], rd_q[1], rresp_q[1], rlast_q[1]}, {32'h0, 2'b10, 32'h0, 2'b10, 1'b1});

      // INCR burst running past the top of the bank
      for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + 32'(i);
      axi_write(4'hB, 32'd56, 8'd3, 2'b01, 4'hF, resp, id_got);
      axi_read(4'hB, 32'd56, 8'd0, 2'b01, 1'b0, id_got);
      check("ovf_idx14", rd_q[0], 32'hC0);
      axi_read(4'hB, 32'd60, 8'd0, 2'b01, 1'b0, id_got);
      check("ovf_idx15", rd_q[0], 32'hC1);
`ifdef S_AXI_REGFILE_RESP_ERR_EN
      check("ovf_bresp", resp, 2'b11);
      axi_read(4'hB, 32'd0, 8'd0, 2'b01, 1'b0, id_got);
      check("ovf_idx0", rd_q[0], RV);
      axi_read(4'hB, 32'd4, 8'd0, 2'b01, 1'b0, id_got);
      check("ovf_idx1", rd_q[0], 32'hDEAD_BEEF);
`else
      check("ovf_bresp", resp, 2'b00);
      axi_read(4'hB, 32'd0, 8'd0, 2'b01, 1'b0, id_got);
      check("ovf_idx0", rd_q[0], 32'hC2);
      axi_read(4'hB, 32'd4, 8'd0, 2'b01, 1'b0, id_got);
      check("ovf_idx1", rd_q[0], 32'hC3);
`endif

      // Same-cycle read and write of index 7 returns the old value
      wd[0] = 32'h5;
      axi_write(4'h1, 32'd28, 8'd0, 2'b01, 4'hF, resp, id_got);
      awid_i = 4'h1; awaddr_i = 32'd28; awlen_i = 8'd0; awburst_i = 2'b01; awvalid_i = 1'b1;
      check("raw_awready", awready_o, 1);
      tick();
      awvalid_i = 1'b0;
      wdata_i = 32'h9; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
      arid_i = 4'h2; araddr_i = 32'd28; arlen_i = 8'd0; arburst_i = 2'b01; arvalid_i = 1'b1;
      check("raw_both_ready", {wready_o, arready_o}, 2'b11);
      tick();
      wvalid_i = 1'b0; wlast_i = 1'b0; arvalid_i = 1'b0;
      check("raw_old", {rvalid_o, rdata_o}, {1'b1, 32'h5});
      check("raw_bvalid", bvalid_o, 1);
      rready_i = 1'b1; bready_i = 1'b1;
      tick();
      rready_i = 1'b0; bready_i = 1'b0;
      $display("[TB] concurrent write/read idx7 -> old data read");
      axi_read(4'h2, 32'd28, 8'd0, 2'b01, 1'b0, id_got);
      check("raw_new", rd_q[0], 32'h9);

      // Reset in the middle of a write burst
      awid_i = 4'h4; awaddr_i = 32'd36; awlen_i = 8'd3; awburst_i = 2'b01; awvalid_i = 1'b1;
      tick();
      awvalid_i = 1'b0;
      wdata_i = 32'h7777_0000; wstrb_i = 4'hF; wvalid_i = 1'b1;
      tick();
      wdata_i = 32'h7777_0001;
      tick();
      wvalid_i = 1'b0;
      areset = 1'b1;
      tick();
      check("midrst_hs", {awready_o, wready_o, bvalid_o}, 3'b100);
      areset = 1'b0;
      $display("[TB] reset during write burst");
      axi_read(4'hC, 32'd0, 8'd15, 2'b01, 1'b0, id_got);
      for (int i = 0; i < 16; i++) check("midrst_reg", {rd_q[i], rresp_q[i]}, {RV, 2'b00});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
